// File: rtl/spi_slave_pkg.sv
// Shared constants and types for the SPI mode-0 slave receiver.
package spi_slave_pkg;

  localparam int SPI_DATA_W = 8;
  localparam int SPI_CNT_W  = $clog2(SPI_DATA_W);

  localparam logic       SPI_CPOL = 1'b0;
  localparam logic       SPI_CPHA = 1'b0;
  localparam logic [1:0] SPI_MODE = {SPI_CPOL, SPI_CPHA};

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_IDLE     = 2'd1,
    ST_BUSY     = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_rx_fifo.sv
// Synchronous byte FIFO; push is accepted when full only if a pop happens in the same cycle.
module spi_rx_fifo
  import spi_slave_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [SPI_DATA_W-1:0]       push_data,
  input  logic                        pop,
  output logic [SPI_DATA_W-1:0]       pop_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [SPI_DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  do_push_s;
  logic                  do_pop_s;

  assign full_s    = (count_r == CW'(FIFO_DEPTH));
  assign empty_s   = (count_r == {CW{1'b0}});
  assign do_pop_s  = pop & ~empty_s;
  assign do_push_s = push & (~full_s | do_pop_s);

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {SPI_DATA_W{1'b0}};
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign full     = full_s;
  assign empty    = empty_s;
  assign count    = count_r;

endmodule

// File: rtl/spi_slave_receiver.sv
// SPI mode-0 slave: oversampled deserializer feeding a byte FIFO with a valid/ready output.
// Optional MISO echo of the previously completed byte when SPI_SLAVE_MISO_EN is defined.
module spi_slave_receiver
  import spi_slave_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sclk,
  input  logic                        mosi,
  input  logic                        cs,
  output logic                        miso,
  output logic [SPI_DATA_W-1:0]       rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        frame_err,
  output logic                        busy
);

  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic                   sclk_prev_r;
  logic                   cs_prev_r;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   cs_s;
  logic                   sclk_rise_s;
  logic                   cs_rise_s;
  logic                   cs_fall_s;

  spi_state_e             state_r;
  spi_state_e             state_nxt_s;
  logic                   busy_s;
  logic                   start_s;
  logic                   end_s;
  logic                   bit_en_s;
  logic                   byte_done_s;
  logic                   frame_err_s;
  logic [SPI_CNT_W-1:0]   bit_cnt_r;
  logic [SPI_DATA_W-2:0]  shift_r;
  logic [SPI_DATA_W-1:0]  done_byte_s;
  logic                   push_r;
  logic [SPI_DATA_W-1:0]  push_data_r;
  logic                   frame_err_r;
  logic                   overflow_r;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;

  // Input synchronizers plus one history register for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      cs_sync_r   <= {SYNC_STAGES{1'b0}};
      sclk_prev_r <= 1'b0;
      cs_prev_r   <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs};
      sclk_prev_r <= sclk_s;
      cs_prev_r   <= cs_s;
    end
  end

  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
  assign cs_s        = cs_sync_r[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_prev_r;
  assign cs_rise_s   = cs_s & ~cs_prev_r;
  assign cs_fall_s   = ~cs_s & cs_prev_r;

  // Frame state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_DISARMED;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: arm only after cs is seen high so a mid-frame join is impossible
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_DISARMED: begin
        if (cs_s) state_nxt_s = ST_IDLE;
        else      state_nxt_s = ST_DISARMED;
      end
      ST_IDLE: begin
        if (cs_fall_s) state_nxt_s = ST_BUSY;
        else           state_nxt_s = ST_IDLE;
      end
      ST_BUSY: begin
        if (cs_rise_s) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_BUSY;
      end
      default: state_nxt_s = ST_DISARMED;
    endcase
  end

  assign busy_s      = (state_r == ST_BUSY);
  assign start_s     = (state_r == ST_IDLE) & cs_fall_s;
  assign end_s       = busy_s & cs_rise_s;
  assign bit_en_s    = busy_s & sclk_rise_s;
  assign byte_done_s = bit_en_s & (bit_cnt_r == {SPI_CNT_W{1'b1}});
  assign done_byte_s = {shift_r, mosi_s};
  // A bit landing in the same cycle as cs rise still leaves a partial byte unless it is the 8th
  assign frame_err_s = end_s & ~byte_done_s & ((bit_cnt_r != {SPI_CNT_W{1'b0}}) | bit_en_s);

  // Deserializer, registered FIFO push and frame error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_r   <= {SPI_CNT_W{1'b0}};
      shift_r     <= {(SPI_DATA_W-1){1'b0}};
      push_r      <= 1'b0;
      push_data_r <= {SPI_DATA_W{1'b0}};
      frame_err_r <= 1'b0;
    end else begin
      push_r      <= byte_done_s;
      push_data_r <= done_byte_s;
      frame_err_r <= frame_err_s;
      if (start_s | end_s) begin
        bit_cnt_r <= {SPI_CNT_W{1'b0}};
      end else if (bit_en_s) begin
        bit_cnt_r <= bit_cnt_r + SPI_CNT_W'(1);
      end
      if (start_s) begin
        shift_r <= {(SPI_DATA_W-1){1'b0}};
      end else if (bit_en_s) begin
        shift_r <= {shift_r[SPI_DATA_W-3:0], mosi_s};
      end
    end
  end

  // Sticky overflow: a push arrived while full and no pop freed a slot
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (push_r & fifo_full_s & ~(rx_ready & ~fifo_empty_s)) begin
      overflow_r <= 1'b1;
    end
  end

  spi_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_r),
    .push_data (push_data_r),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count)
  );

`ifdef SPI_SLAVE_MISO_EN
  logic                  sclk_fall_s;
  logic [SPI_DATA_W-1:0] last_byte_r;
  logic [SPI_DATA_W-1:0] tx_r;

  assign sclk_fall_s = ~sclk_s & sclk_prev_r;

  // Echo register: reload on frame start or byte completion, shift on sclk fall
  always_ff @(posedge clk) begin
    if (rst) begin
      last_byte_r <= {SPI_DATA_W{1'b0}};
      tx_r        <= {SPI_DATA_W{1'b0}};
    end else if (byte_done_s) begin
      last_byte_r <= done_byte_s;
      tx_r        <= done_byte_s;
    end else if (start_s) begin
      tx_r <= last_byte_r;
    end else if (busy_s & sclk_fall_s) begin
      tx_r <= {tx_r[SPI_DATA_W-2:0], 1'b0};
    end
  end

  assign miso = busy_s & tx_r[SPI_DATA_W-1];
`else
  assign miso = 1'b0;
`endif

  assign rx_valid  = ~fifo_empty_s;
  assign overflow  = overflow_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_s;

endmodule

// File: tb/tb_spi_slave_receiver.sv
// Directed scoreboard bench for spi_slave_receiver (works with or without SPI_SLAVE_MISO_EN).
module tb_spi_slave_receiver;

  localparam int FIFO_DEPTH  = 4;
  localparam int SYNC_STAGES = 2;
  localparam int CW          = $clog2(FIFO_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          sclk;
  logic          mosi;
  logic          cs;
  logic          miso;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          frame_err;
  logic          busy;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tb_last;

  spi_slave_receiver #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .mosi       (mosi),
    .cs         (cs),
    .miso       (miso),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_valid"},   rx_valid,   32'd0);
    check({tag, "_rx_data"},    rx_data,    32'd0);
    check({tag, "_fifo_count"}, fifo_count, 32'd0);
    check({tag, "_overflow"},   overflow,   32'd0);
    check({tag, "_frame_err"},  frame_err,  32'd0);
    check({tag, "_busy"},       busy,       32'd0);
    check({tag, "_miso"},       miso,       32'd0);
  endtask

  // One frame: nbits MSB-first with 4-clk half periods; optional latency probe and pop-at-push
  task automatic send_frame(input logic [7:0] b, input int nbits, input bit measure,
                            input bit pop_at_push, input bit end_cs);
    logic [7:0] miso_b;
    logic [7:0] exp_miso;
    int         fe_cnt;
    miso_b = 8'h00;
`ifdef SPI_SLAVE_MISO_EN
    exp_miso = tb_last;
`else
    exp_miso = 8'h00;
`endif
    cs = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      repeat (4) @(negedge clk);
      miso_b = {miso_b[6:0], miso};
      sclk = 1'b1;
      if (i == 7) begin
        for (int k = 1; k <= 4; k++) begin
          @(posedge clk);
          #1;
          if (measure) check($sformatf("latency_rx_valid_clk%0d", k), rx_valid, (k == 4) ? 32'd1 : 32'd0);
          if (pop_at_push && k == 3) begin
            check("head_before_pop_push", rx_data, exp_q[0]);
            rx_ready = 1'b1;
          end
          if (pop_at_push && k == 4) begin
            rx_ready = 1'b0;
            void'(exp_q.pop_front());
          end
        end
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(b);
        tb_last = b;
        @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      sclk = 1'b0;
    end
    if (nbits == 8) check("miso_echo", miso_b, exp_miso);
    repeat (4) @(negedge clk);
    if (end_cs) begin
      cs = 1'b1;
      fe_cnt = 0;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk);
        #1;
        if (frame_err) fe_cnt++;
      end
      check("frame_err_pulse_cycles", fe_cnt, (nbits != 8) ? 32'd1 : 32'd0);
      repeat (3) @(negedge clk);
    end
  endtask

  // Wait (bounded) for a byte, compare against the scoreboard head, then pop it
  task automatic pop_check(input string tag);
    int         t;
    logic [7:0] expv;
    t = 0;
    while (!rx_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_valid"}, rx_valid, 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed byte 0x%0h with an empty scoreboard", tag, rx_data);
    end else begin
      expv = exp_q.pop_front();
      check({tag, "_data"}, rx_data, expv);
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    sclk     = 1'b0;
    mosi     = 1'b0;
    cs       = 1'b1;
    rx_ready = 1'b0;
    tb_last  = 8'h00;
    repeat (4) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte with latency probe
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1);
    check("t1_fifo_count", fifo_count, exp_q.size());
    check("t1_overflow", overflow, 32'd0);
    pop_check("t1_pop");

    // Overflow: five bytes into a four-deep FIFO
    for (int v = 1; v <= 5; v++) send_frame(v[7:0], 8, 1'b0, 1'b0, 1'b1);
    check("t2_overflow", overflow, 32'd1);
    check("t2_fifo_count", fifo_count, 32'd4);
    for (int v = 1; v <= 4; v++) pop_check($sformatf("t2_pop%0d", v));
    check("t2_fifo_empty", fifo_count, 32'd0);
    check("t2_overflow_sticky", overflow, 32'd1);

    // Partial frame then a good byte
    send_frame(8'hE0, 3, 1'b0, 1'b0, 1'b1);
    check("t3_fifo_count", fifo_count, 32'd0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
    pop_check("t3_pop");

    // Reset in the middle of bit 5 with cs low
    send_frame(8'hB0, 4, 1'b0, 1'b0, 1'b0);
    mosi = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    tb_last = 8'h00;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      mosi = ~mosi;
      repeat (4) @(negedge clk);
      sclk = 1'b1;
    end
    repeat (4) @(negedge clk);
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    check("t4_busy_disarmed", busy, 32'd0);
    check("t4_fifo_count", fifo_count, 32'd0);
    cs = 1'b1;
    repeat (6) @(negedge clk);
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1);
    pop_check("t4_pop");

    // Full FIFO with a pop in the push cycle
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'h44, 8, 1'b0, 1'b0, 1'b1);
    check("t5_fifo_full", fifo_count, 32'd4);
    send_frame(8'h55, 8, 1'b0, 1'b1, 1'b1);
    check("t5_fifo_count", fifo_count, 32'd4);
    check("t5_overflow", overflow, 32'd0);
    for (int v = 1; v <= 4; v++) pop_check($sformatf("t5_pop%0d", v));

    // Echo: second frame shifts out the first byte when MISO is enabled
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
    pop_check("t6_pop1");
    pop_check("t6_pop2");
    check("t6_miso_idle", miso, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
